fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_WORDS, default 32: instruction memory depth in 32-bit words.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 stall_i  input  1  hold PC and IF/ID register (load-use hazard).
REQ-006 flush_i  input  1  squash the IF/ID register contents.
REQ-007 redirect_i  input  1  taken branch/jump; load the target into the PC.
REQ-008 target_i  input  32  redirect byte address.
REQ-009 instr_i  input  32  instruction word returned combinationally by instruction memory for pc_o.
REQ-010 pc_o  output  32  current fetch byte address; drives instruction memory addr_i.
REQ-011 ifid_instr_o  output  32  registered instruction for the decode stage.
REQ-012 ifid_pc4_o  output  32  registered fetch PC + 4.
REQ-013 ifid_valid_o  output  1  IF/ID register holds a real instruction.
REQ-014 oob_o  output  1  sticky flag: a fetch occurred at or beyond IMEM_WORDS*4.
REQ-015 fetch_cnt_o  output  32  count of valid instructions captured into IF/ID.

Function
REQ-016 All state SHALL update only on the rising edge of clk_i.
REQ-017 PC next-state SHALL follow this priority: redirect_i high -> {target_i[31:2],2'b00}; otherwise stall_i high -> hold; otherwise pc + 4.
REQ-018 PC + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 IF/ID next-state SHALL follow this priority: flush_i or redirect_i high -> instr 32'h0, pc4 32'h0, valid 0; otherwise stall_i high -> hold all fields; otherwise capture instr_i, pc_o + 4, valid 1.
REQ-020 Capture latency SHALL be one cycle: the instruction at pc_o in cycle N SHALL appear on ifid_instr_o in cycle N+1.
REQ-021 When pc_o[31:2] >= IMEM_WORDS and no flush, redirect or stall is active, IF/ID SHALL capture instr 32'h0 with valid 0, and oob_o SHALL set.
REQ-022 oob_o SHALL remain set until reset.
REQ-023 fetch_cnt_o SHALL increment by 1, wrapping modulo 2^32, exactly in cycles where IF/ID captures with valid 1.
REQ-024 fetch_cnt_o SHALL hold in every other cycle.
REQ-025 When stall_i and flush_i are high together, the PC SHALL hold and IF/ID SHALL flush.
REQ-026 When stall_i and redirect_i are high together, the PC SHALL load the target and IF/ID SHALL flush.
REQ-027 The block SHALL be a single-state pipeline stage with no FSM beyond the PC, IF/ID and flag registers.
REQ-028 No output SHALL depend combinationally on stall_i, flush_i or redirect_i, except pc_o's source register.

Reset
REQ-029 With rst_i low at a rising edge, the block SHALL set: pc_o = RESET_PC, ifid_instr_o = 0, ifid_pc4_o = 0, ifid_valid_o = 0, oob_o = 0, fetch_cnt_o = 0.
REQ-030 Reset SHALL override stall_i, flush_i and redirect_i.
REQ-031 Reset asserted mid-stream SHALL discard any in-flight instruction, and fetching SHALL resume at RESET_PC on the first edge after rst_i returns high.

Verification
REQ-032 Sequential fetch: reset, then 4 free cycles with memory word k = 32'h1000_0000+k -> pc_o steps 0,4,8,12; ifid_instr_o lags by one cycle; fetch_cnt_o = 4.
REQ-033 Stall: stall_i high for 2 cycles at pc_o = 8 -> pc_o stays 8; ifid_instr_o holds word 1; fetch_cnt_o frozen; the sequence resumes at 12.
REQ-034 Redirect: redirect_i with target_i = 32'h0000_0023 at pc_o = 12 -> next pc_o = 32'h20; ifid_valid_o = 0 for one cycle; next ifid_instr_o = word 8.
REQ-035 Out-of-range fetch: redirect to 32'h80 with IMEM_WORDS = 32 -> ifid_valid_o = 0; ifid_instr_o = 0; oob_o = 1 and still 1 after a later redirect to 0.
REQ-036 Simultaneous events: stall_i and flush_i high at pc_o = 4 -> pc_o holds 4; ifid_valid_o = 0. Then stall_i and redirect_i high with target 0 -> pc_o = 0.
REQ-037 Mid-operation reset: rst_i low for one cycle at pc_o = 16 -> all outputs at reset values. First fetch after release is at RESET_PC; fetch_cnt_o restarts from 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with program counter and IF/ID register.
//
// Ports:
//   clk_i         rising-edge clock for all state
//   rst_i         synchronous active-low reset (overrides every other control)
//   stall_i       hold PC and IF/ID register
//   flush_i       squash IF/ID register contents
//   redirect_i    load target_i (word aligned) into PC and squash IF/ID
//   target_i      redirect byte address
//   instr_i       instruction word from memory at pc_o (combinational)
//   pc_o          current fetch byte address
//   ifid_instr_o  registered instruction for decode
//   ifid_pc4_o    registered fetch PC + 4
//   ifid_valid_o  IF/ID holds a real instruction
//   oob_o         sticky: a fetch happened at or beyond IMEM_WORDS*4
//   fetch_cnt_o   number of valid instructions captured into IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        oob_o,
  output logic [31:0] fetch_cnt_o
);

  localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_oob;
  logic        squash;

  assign pc_plus4  = pc + 32'd4;
  assign fetch_oob = (pc[31:2] >= WORD_LIMIT);
  assign squash    = flush_i | redirect_i;

  // Program counter: redirect beats stall beats sequential advance.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= target_i & 32'hFFFF_FFFC;
    end else if (!stall_i) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register, fetch counter and sticky out-of-range flag.
  // An out-of-range fetch still advances the pipeline but captures a bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ifid_instr_o <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
      oob_o        <= 1'b0;
      fetch_cnt_o  <= '0;
    end else if (squash) begin
      ifid_instr_o <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
    end else if (!stall_i) begin
      ifid_pc4_o <= pc_plus4;
      if (fetch_oob) begin
        ifid_instr_o <= '0;
        ifid_valid_o <= 1'b0;
        oob_o        <= 1'b1;
      end else begin
        ifid_instr_o <= instr_i;
        ifid_valid_o <= 1'b1;
        fetch_cnt_o  <= fetch_cnt_o + 32'd1;
      end
    end
  end

  assign pc_o = pc;

endmodule
